layer6_pool_result_buffer: RTL and testbench



---
 rtl/layer6_pool_result_buffer_pkg.sv | 16 +
 rtl/layer6_pool_result_buffer_ram.sv | 28 ++
 rtl/layer6_pool_result_buffer.sv | 143 ++++++++++++++
 tb/tb_layer6_pool_result_buffer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer6_pool_result_buffer_pkg.sv
// Layer-6 shared defines: word lengths, pooled frame size, buffer states.
// Imported by the pooled result buffer and its pixel RAM.
package layer6_pool_result_buffer_pkg;

    localparam int L6_DATA_W    = 128;
    localparam int L6_ADDR_W    = 16;
    localparam int L6_POOL_ROWS = 4;
    localparam int L6_POOL_COLS = 4;

    typedef enum logic [1:0] {
        FILL,
        DONE_PULSE,
        READY
    } buf_state_e;

endpackage

// File: rtl/layer6_pool_result_buffer_ram.sv
// Pooled pixel storage: synchronous write, registered synchronous read.
// Contents are never reset; a new frame overwrites them.
module pool_pixel_ram #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 128,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/layer6_pool_result_buffer.sv
// Layer-6 pooled result buffer: fills from the pooling stage, then serves
// row/col reads to the next layer until it is released.
module layer6_pool_result_buffer
    import layer6_pool_result_buffer_pkg::*;
#(
    parameter int DATA_W = L6_DATA_W,
    parameter int ROWS   = L6_POOL_ROWS,
    parameter int COLS   = L6_POOL_COLS,
    parameter int ADDR_W = L6_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_enable,
    input  logic [ADDR_W-1:0] output_row,
    input  logic [ADDR_W-1:0] output_col,
    input  logic [DATA_W-1:0] output_data,
    input  logic              layer6_calculation_done,
    output logic              pixel_store_done,
    input  logic              read_pixel_signal,
    input  logic [ADDR_W-1:0] read_row_addr,
    input  logic [ADDR_W-1:0] read_col_addr,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    input  logic              next_layer_done,
    output logic              buffer_ready,
    output logic              store_error
);

    localparam int DEPTH = ROWS * COLS;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [ADDR_W-1:0] ROWS_A  = ADDR_W'(ROWS);
    localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    buf_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_set;
    logic              wr_en, rd_en;
    logic              wr_ok, rd_ok, rd_req;
    logic              rd_zero_q;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [DATA_W-1:0] ram_q;

    // Range checks use the full address width before narrowing to an index.
    assign wr_ok  = (output_row < ROWS_A) && (output_col < COLS_A);
    assign rd_ok  = (read_row_addr < ROWS_A) && (read_col_addr < COLS_A);
    assign wr_idx = IDX_W'(output_row) * IDX_W'(COLS) + IDX_W'(output_col);
    assign rd_idx = IDX_W'(read_row_addr) * IDX_W'(COLS)
                  + IDX_W'(read_col_addr);
    assign rd_req = read_pixel_signal && (state_q != FILL);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        wr_en   = 1'b0;
        rd_en   = rd_req && rd_ok;
        unique case (state_q)
            FILL: begin
                if (save_enable) begin
                    if (wr_ok) begin
                        wr_en = 1'b1;
                        if (cnt_q != DEPTH_C) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        err_set = 1'b1;
                    end
                end
                // The last save normally lands in the same cycle as done.
                if (layer6_calculation_done) begin
                    state_d = DONE_PULSE;
                    if (cnt_d != DEPTH_C) begin
                        err_set = 1'b1;
                    end
                end
            end
            DONE_PULSE: begin
                state_d = READY;
                if (save_enable) begin
                    err_set = 1'b1;
                end
            end
            READY: begin
                if (save_enable) begin
                    err_set = 1'b1;
                end
                if (next_layer_done) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
        if (rd_req && !rd_ok) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            store_error <= 1'b0;
            read_valid  <= 1'b0;
            rd_zero_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            read_valid <= rd_req;
            if (err_set) begin
                store_error <= 1'b1;
            end
            if (rd_req) begin
                rd_zero_q <= !rd_ok;
            end
        end
    end

    pool_pixel_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (output_data),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (ram_q)
    );

    // The RAM output register is not reset; mask it until a valid read.
    assign read_data        = rd_zero_q ? '0 : ram_q;
    assign pixel_store_done = (state_q == DONE_PULSE);
    assign buffer_ready     = (state_q != FILL);

endmodule

// File: tb/tb_layer6_pool_result_buffer.sv
// Directed bench for the layer-6 pooled result buffer.
// Each task drives one scenario and checks its own results.
module tb_layer6_pool_result_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         save_enable = 1'b0;
    logic [15:0]  output_row = '0;
    logic [15:0]  output_col = '0;
    logic [127:0] output_data = '0;
    logic         layer6_calculation_done = 1'b0;
    logic         pixel_store_done;
    logic         read_pixel_signal = 1'b0;
    logic [15:0]  read_row_addr = '0;
    logic [15:0]  read_col_addr = '0;
    logic [127:0] read_data;
    logic         read_valid;
    logic         next_layer_done = 1'b0;
    logic         buffer_ready;
    logic         store_error;

    int errors = 0;
    int checks = 0;

    layer6_pool_result_buffer dut (
        .clk                     (clk),
        .rst                     (rst),
        .save_enable             (save_enable),
        .output_row              (output_row),
        .output_col              (output_col),
        .output_data             (output_data),
        .layer6_calculation_done (layer6_calculation_done),
        .pixel_store_done        (pixel_store_done),
        .read_pixel_signal       (read_pixel_signal),
        .read_row_addr           (read_row_addr),
        .read_col_addr           (read_col_addr),
        .read_data               (read_data),
        .read_valid              (read_valid),
        .next_layer_done         (next_layer_done),
        .buffer_ready            (buffer_ready),
        .store_error             (store_error)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pix(input int v);
        logic [15:0] lane;
        lane = 16'(v);
        return {8{lane}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input int base, input int n, input bit done);
        for (int i = 0; i < n; i++) begin
            save_enable = 1'b1;
            output_row  = 16'(i / 4);
            output_col  = 16'(i % 4);
            output_data = pix(base + i);
            layer6_calculation_done = done && (i == n - 1);
            tick();
        end
        save_enable = 1'b0;
        layer6_calculation_done = 1'b0;
    endtask

    task automatic release_buffer();
        next_layer_done = 1'b1;
        tick();
        next_layer_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({pixel_store_done, read_valid, buffer_ready, store_error}
            !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                {pixel_store_done, read_valid, buffer_ready, store_error});
        end
        checks++;
        if (read_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", read_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        write_frame(0, 16, 1'b1);
        checks++;
        if ({pixel_store_done, buffer_ready, store_error} !== 3'b110) begin
            errors++;
            $display("FAIL full_done_pulse: got %b expected 110",
                {pixel_store_done, buffer_ready, store_error});
        end
        tick();
        checks++;
        if ({pixel_store_done, buffer_ready} !== 2'b01) begin
            errors++;
            $display("FAIL full_pulse_end: got %b expected 01",
                {pixel_store_done, buffer_ready});
        end
        read_pixel_signal = 1'b1;
        read_row_addr = 16'd2;
        read_col_addr = 16'd3;
        tick();
        read_pixel_signal = 1'b0;
        checks++;
        if (read_valid !== 1'b1 || read_data !== pix(11)) begin
            errors++;
            $display("FAIL full_read_2_3: got v=%b %h expected v=1 %h",
                read_valid, read_data, pix(11));
        end
        tick();
        checks++;
        if (read_valid !== 1'b0 || read_data !== pix(11)) begin
            errors++;
            $display("FAIL full_read_hold: got v=%b %h expected v=0 %h",
                read_valid, read_data, pix(11));
        end
    endtask

    task automatic test_back_to_back();
        read_pixel_signal = 1'b1;
        for (int i = 0; i < 16; i++) begin
            read_row_addr = 16'(i / 4);
            read_col_addr = 16'(i % 4);
            tick();
            checks++;
            if (read_valid !== 1'b1 || read_data !== pix(i)) begin
                errors++;
                $display("FAIL b2b_read_%0d: got v=%b %h expected v=1 %h",
                    i, read_valid, read_data, pix(i));
            end
        end
        read_pixel_signal = 1'b0;
        tick();
    endtask

    task automatic test_ready_write();
        checks++;
        if (store_error !== 1'b0) begin
            errors++;
            $display("FAIL ready_err_pre: got %b expected 0", store_error);
        end
        save_enable = 1'b1;
        output_row  = 16'd0;
        output_col  = 16'd0;
        output_data = {128{1'b1}};
        tick();
        save_enable = 1'b0;
        checks++;
        if (store_error !== 1'b1) begin
            errors++;
            $display("FAIL ready_write_err: got %b expected 1", store_error);
        end
        read_pixel_signal = 1'b1;
        read_row_addr = 16'd0;
        read_col_addr = 16'd0;
        tick();
        checks++;
        if (read_valid !== 1'b1 || read_data !== pix(0)) begin
            errors++;
            $display("FAIL ready_write_kept: got v=%b %h expected v=1 %h",
                read_valid, read_data, pix(0));
        end
        read_row_addr = 16'd3;
        read_col_addr = 16'd3;
        tick();
        read_row_addr = 16'd4;
        read_col_addr = 16'd0;
        tick();
        read_pixel_signal = 1'b0;
        checks++;
        if (read_valid !== 1'b1 || read_data !== '0) begin
            errors++;
            $display("FAIL oor_read: got v=%b %h expected v=1 0",
                read_valid, read_data);
        end
    endtask

    task automatic test_release_second_frame();
        next_layer_done   = 1'b1;
        read_pixel_signal = 1'b1;
        read_row_addr = 16'd3;
        read_col_addr = 16'd3;
        tick();
        next_layer_done   = 1'b0;
        read_pixel_signal = 1'b0;
        checks++;
        if (read_valid !== 1'b1 || read_data !== pix(15)) begin
            errors++;
            $display("FAIL release_read: got v=%b %h expected v=1 %h",
                read_valid, read_data, pix(15));
        end
        checks++;
        if (buffer_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_ready: got %b expected 0", buffer_ready);
        end
        write_frame(100, 16, 1'b1);
        checks++;
        if ({pixel_store_done, buffer_ready} !== 2'b11) begin
            errors++;
            $display("FAIL second_pulse: got %b expected 11",
                {pixel_store_done, buffer_ready});
        end
        read_pixel_signal = 1'b1;
        read_row_addr = 16'd1;
        read_col_addr = 16'd2;
        tick();
        read_pixel_signal = 1'b0;
        checks++;
        if (read_valid !== 1'b1 || read_data !== pix(106)) begin
            errors++;
            $display("FAIL second_read_1_2: got v=%b %h expected v=1 %h",
                read_valid, read_data, pix(106));
        end
    endtask

    task automatic test_reset_mid_fill();
        release_buffer();
        write_frame(200, 7, 1'b0);
        read_pixel_signal = 1'b1;
        read_row_addr = 16'd0;
        read_col_addr = 16'd1;
        tick();
        read_pixel_signal = 1'b0;
        checks++;
        if (read_valid !== 1'b0 || read_data !== pix(106)) begin
            errors++;
            $display("FAIL fill_read: got v=%b %h expected v=0 %h",
                read_valid, read_data, pix(106));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({pixel_store_done, read_valid, buffer_ready, store_error}
            !== 4'b0000 || read_data !== '0) begin
            errors++;
            $display("FAIL mid_reset: got %b %h expected 0000 0",
                {pixel_store_done, read_valid, buffer_ready, store_error},
                read_data);
        end
        write_frame(50, 16, 1'b1);
        checks++;
        if ({pixel_store_done, buffer_ready, store_error} !== 3'b110) begin
            errors++;
            $display("FAIL after_reset_frame: got %b expected 110",
                {pixel_store_done, buffer_ready, store_error});
        end
        read_pixel_signal = 1'b1;
        read_row_addr = 16'd3;
        read_col_addr = 16'd1;
        tick();
        read_pixel_signal = 1'b0;
        checks++;
        if (read_valid !== 1'b1 || read_data !== pix(63)) begin
            errors++;
            $display("FAIL after_reset_read: got v=%b %h expected v=1 %h",
                read_valid, read_data, pix(63));
        end
    endtask

    task automatic test_short_frame();
        release_buffer();
        write_frame(0, 15, 1'b1);
        checks++;
        if ({pixel_store_done, buffer_ready, store_error} !== 3'b111) begin
            errors++;
            $display("FAIL short_frame: got %b expected 111",
                {pixel_store_done, buffer_ready, store_error});
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_ready_write();
        test_release_second_frame();
        test_reset_mid_fill();
        test_short_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
